tlul_socket_1n_lite: RTL
========================

Name: tlul_socket_1n_lite

Overview:
- One-host to N-device TL-UL steering socket.
- Routes each A-channel request to the device chosen by an externally decoded select.
- Unmapped selects go to a dedicated error port, which drives the downstream error responder.
- Tracks outstanding transactions so that D-channel responses return in order from the device that owns them.

Parameters:
- N, 4, number of device ports (1..15).
- MaxOutstanding, 8, maximum in-flight requests; the counter is $clog2(MaxOutstanding+1) bits wide.
- NWD, $clog2(N+1), width of dev_select_i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- tl_h_i  in  tlul_pkg::tl_h2d_t  host request.
- tl_h_o  out  tlul_pkg::tl_d2h_t  host response.
- dev_select_i  in  NWD  target for the current tl_h_i A beat; values >= N select the error port.
- tl_d_o  out  tlul_pkg::tl_h2d_t [N]  device requests.
- tl_d_i  in  tlul_pkg::tl_d2h_t [N]  device responses.
- tl_err_o  out  tlul_pkg::tl_h2d_t  request to the error responder.
- tl_err_i  in  tlul_pkg::tl_d2h_t  error responder response.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - outstanding count = 0, dev_sel_q = 0.
  - While rst_i is high, all a_valid outputs and tl_h_o.d_valid are forced low, and tl_h_o.a_ready is 0.
  - Reset mid-transaction drops all in-flight tracking. Late device responses arriving after reset are not forwarded until a new request re-establishes dev_sel_q.
- Hold condition:
  - hold = (cnt != 0 && dev_select_i != dev_sel_q) || (cnt == MaxOutstanding).
- A channel, combinational pass-through with zero latency:
  - tl_d_o[i] carries all A fields of tl_h_i.
  - tl_d_o[i].a_valid = tl_h_i.a_valid & ~hold & (dev_select_i == i).
  - tl_err_o works the same way, with select >= N.
  - tl_h_o.a_ready = ~hold & the a_ready of the selected target.
  - a_ready of non-selected targets is ignored.
- Accept event: tl_h_i.a_valid & tl_h_o.a_ready. On accept, dev_sel_q <= dev_select_i; select values >= N are stored as N.
- Response event: tl_h_o.d_valid & tl_h_i.d_ready.
- Counter update:
  - cnt +1 on accept only.
  - cnt -1 on response only.
  - Unchanged on simultaneous accept and response.
  - Never wraps: increment is blocked at MaxOutstanding by hold.
  - A response with cnt == 0 is not possible because d_valid is gated.
- D channel:
  - tl_h_o D fields are muxed from target dev_sel_q.
  - tl_h_o.d_valid = selected d_valid & (cnt != 0).
  - d_ready is driven only to target dev_sel_q and is 0 to all others.
  - Responses from non-selected targets are never forwarded.
- Same-cycle select change:
  - A request to a different target stalls until cnt returns to 0.
  - The cycle in which the last response completes still shows hold = 1 (registered count).
  - The new target is accepted on the next cycle.
- Ordering: in-order per target is guaranteed by stalling target switches. No reordering buffer.
- tl_h_o.a_ready may depend combinationally on tl_h_i.a_valid only through dev_select_i. There is no comb path from a_valid to a_ready otherwise.

Optional Feature:
- Macro: TLUL_SOCKET_1N_PERF_EN.
- When defined:
  - Adds output stall_cnt_o [15:0].
  - Increments each cycle where tl_h_i.a_valid=1 and hold=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single read to dev 2:
  - a_valid with dev_select=2, Get → only tl_d_o[2].a_valid=1.
  - After dev 2 returns AccessAckData with d_data=32'hCAFE0001, the host sees it with cnt back to 0.
- Back-to-back to dev 1:
  - 8 accepted Gets with no responses → cnt=8.
  - A 9th request stalls (a_ready=0).
  - One response frees the slot, and the 9th is accepted the following cycle.
- Target switch:
  - 2 outstanding on dev 0, new request for dev 3 → stalled until both dev 0 responses complete.
  - Then accepted; dev 0 d_ready=0 afterward.
- Unmapped select:
  - dev_select=N (4) with PutFullData → tl_err_o.a_valid=1.
  - The error responder's AccessAck with d_data=all-ones reaches the host unchanged.
- Simultaneous accept and response on the same target with cnt=3 → cnt stays 3.
- Reset mid-burst:
  - rst_i asserted with cnt=5 → next cycle cnt=0, all valids low.
  - With TLUL_SOCKET_1N_PERF_EN defined, stall_cnt_o=0.

Source files
------------

// File: rtl/tlul_socket_1n_lite.sv
// -----------------------------------------------------------------------------
// tlul_pkg / tlul_socket_1n_lite
//
// tlul_pkg holds the TL-UL channel structs and opcodes that the socket uses.
//
// tlul_socket_1n_lite steers one TL-UL host to N devices plus an error port.
// A requests pass straight through (zero latency) to the target picked by
// dev_select_i. Any select value >= N routes to the error port, which feeds
// the downstream error responder. D responses come back from the target that
// owns the in-flight requests. Only one target can have requests in flight at
// a time, so a request to a different target stalls until the count drains.
// That is what keeps responses in order without a reorder buffer.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   tl_h_i       host request (A channel + d_ready)
//   tl_h_o       host response (D channel + a_ready)
//   dev_select_i decoded target for the current A beat (>= N -> error port)
//   tl_d_o[N]    device requests
//   tl_d_i[N]    device responses
//   tl_err_o     request to the error responder
//   tl_err_i     response from the error responder
//   stall_cnt_o  (only with TLUL_SOCKET_1N_PERF_EN) saturating count of cycles
//                in which a valid request was held off
//
// Optional feature macro: TLUL_SOCKET_1N_PERF_EN
// -----------------------------------------------------------------------------
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_socket_1n_lite
    import tlul_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned NWD           = $clog2(N + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  tl_h2d_t        tl_h_i,
    output tl_d2h_t        tl_h_o,
    input  logic [NWD-1:0] dev_select_i,
    output tl_h2d_t        tl_d_o [N],
    input  tl_d2h_t        tl_d_i [N],
    output tl_h2d_t        tl_err_o,
    input  tl_d2h_t        tl_err_i
`ifdef TLUL_SOCKET_1N_PERF_EN
    ,
    output logic [15:0]    stall_cnt_o
`endif
);

    localparam int unsigned    CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    // The error port is target index N everywhere inside the socket.
    localparam logic [NWD-1:0] ErrIdx = NWD'(N);

    logic [CntW-1:0] cnt_q;
    logic [NWD-1:0]  dev_sel_q;
    logic [NWD-1:0]  sel_n;
    logic            hold;
    logic            a_ready;
    logic            d_valid;
    logic            accept;
    logic            response;
    tl_d2h_t         rsp [N+1];

    // Fold every unmapped select onto the single error index, so "same
    // target" comparisons treat all unmapped values as one destination.
    assign sel_n = (dev_select_i >= ErrIdx) ? ErrIdx : dev_select_i;

    // Hold uses the registered count: in the cycle the last response retires,
    // a switch to another target is still held and goes through next cycle.
    assign hold = ((cnt_q != '0) && (sel_n != dev_sel_q)) || (cnt_q == CntMax);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rsp[i] = tl_d_i[i];
        end
        rsp[N] = tl_err_i;
    end

    // a_ready depends on a_valid only through the select, never directly.
    assign a_ready  = ~rst_i & ~hold & rsp[sel_n].a_ready;
    assign d_valid  = ~rst_i & rsp[dev_sel_q].d_valid & (cnt_q != '0);
    assign accept   = tl_h_i.a_valid & a_ready;
    assign response = d_valid & tl_h_i.d_ready;

    always_comb begin
        // NOTE: every output gets a full default first, so no path through
        // this block can leave a bit unassigned and infer a latch.
        tl_h_o         = rsp[dev_sel_q];
        tl_h_o.a_ready = a_ready;
        tl_h_o.d_valid = d_valid;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid & ~rst_i & ~hold & (sel_n == NWD'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready & (dev_sel_q == NWD'(i));
        end
        tl_err_o         = tl_h_i;
        tl_err_o.a_valid = tl_h_i.a_valid & ~rst_i & ~hold & (sel_n == ErrIdx);
        tl_err_o.d_ready = tl_h_i.d_ready & (dev_sel_q == ErrIdx);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            dev_sel_q <= '0;
        end else begin
            if (accept) begin
                dev_sel_q <= sel_n;
            end
            // Accept and response in the same cycle cancel out. hold keeps
            // the count from passing CntMax, and d_valid is gated at zero.
            case ({accept, response})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef TLUL_SOCKET_1N_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (tl_h_i.a_valid && hold && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`else
    // No stall counter in this build. Routing and tracking are unchanged.
`endif

endmodule
